// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the OAM DMA bus arbiter: state and region
// encodings, the memory-map constants, and the source-page remap helper.
package oam_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

  typedef enum logic [1:0] {
    MAIN   = 2'd0,
    HRAM   = 2'd1,
    DMAREG = 2'd2
  } region_t;

  localparam logic [15:0] HRAM_LO      = 16'hFF80;
  localparam logic [15:0] HRAM_HI      = 16'hFFFE;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam int          OAM_BYTES    = 160;

  // Pages E0..FF alias back onto the work-RAM pages C0..DF.
  function automatic logic [7:0] eff_src(input logic [7:0] src);
    return (src >= 8'hE0) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// Bundle of the core-side, main-bus, HRAM and OAM signals around the arbiter.
// master is the arbiter's view; slave is the view of the surrounding system.
interface oam_dma_arbiter_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write;
  logic [7:0]  cpu_rdata;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;

  logic [6:0]  hram_addr;
  logic [7:0]  hram_wdata;
  logic        hram_write;
  logic [7:0]  hram_rdata;

  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_write;

  logic        dma_active;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_write, mem_rdata, hram_rdata,
    output cpu_rdata, mem_addr, mem_wdata, mem_write,
    output hram_addr, hram_wdata, hram_write,
    output oam_addr, oam_wdata, oam_write, dma_active
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_write, mem_rdata, hram_rdata,
    input  cpu_rdata, mem_addr, mem_wdata, mem_write,
    input  hram_addr, hram_wdata, hram_write,
    input  oam_addr, oam_wdata, oam_write, dma_active
  );

endinterface

// File: rtl/bus_decode_m.sv
// Combinational region decode of the core address: DMA register, HRAM or main.
module bus_decode_m
  import oam_dma_arbiter_pkg::*;
#(
  parameter logic [15:0] DMA_REG = DMA_REG_ADDR
) (
  input  logic [15:0] cpu_addr_i,
  output region_t     region_o
);

  always_comb begin
    region_o = MAIN;
    if (cpu_addr_i == DMA_REG) begin
      region_o = DMAREG;
    end else if ((cpu_addr_i >= HRAM_LO) && (cpu_addr_i <= HRAM_HI)) begin
      region_o = HRAM;
    end
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// Main-bus arbiter between the core and the OAM DMA engine; owns the DMA
// source register and a private HRAM port so the core runs from HRAM meanwhile.
module oam_dma_arbiter #(
  parameter int          OAM_BYTES   = oam_dma_arbiter_pkg::OAM_BYTES,
  parameter logic [15:0] DMA_REG     = oam_dma_arbiter_pkg::DMA_REG_ADDR,
  parameter int          START_DELAY = 1
) (
  input logic                clk,
  input logic                rst,
  oam_dma_arbiter_if.master  bus
);

  import oam_dma_arbiter_pkg::*;

  localparam logic [7:0] LAST_IDX   = 8'(OAM_BYTES - 1);
  localparam logic [7:0] DELAY_INIT = 8'(START_DELAY);

  region_t    region;
  dma_state_t state_q, state_d;

  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] oam_addr_q, oam_addr_d;
  logic [7:0] oam_wdata_q, oam_wdata_d;
  logic       oam_write_q, oam_write_d;
  logic       dma_active_q, dma_active_d;

  logic       reg_wr;
  logic       in_xfer;

  bus_decode_m #(
    .DMA_REG (DMA_REG)
  ) u_decode (
    .cpu_addr_i (bus.cpu_addr),
    .region_o   (region)
  );

  assign reg_wr  = bus.cpu_write && (region == DMAREG);
  assign in_xfer = (state_q == XFER);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A source-register write restarts from any state, including the last XFER read.
  always_comb begin
    state_d = state_q;
    if (reg_wr) begin
      state_d = START;
    end else begin
      case (state_q)
        START:   if (cnt_q <= 8'd1) state_d = XFER;
        XFER:    if (idx_q == LAST_IDX) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bus.mem_addr   = bus.cpu_addr;
    bus.mem_wdata  = bus.cpu_wdata;
    bus.mem_write  = bus.cpu_write && (region == MAIN);
    if (in_xfer) begin
      bus.mem_addr  = {eff_src(src_q), idx_q};
      bus.mem_write = 1'b0;
    end
    if (!rst) begin
      bus.mem_write = 1'b0;
    end

    case (region)
      HRAM:    bus.cpu_rdata = bus.hram_rdata;
      DMAREG:  bus.cpu_rdata = src_q;
      default: bus.cpu_rdata = in_xfer ? 8'hFF : bus.mem_rdata;
    endcase

    bus.hram_addr  = bus.cpu_addr[6:0];
    bus.hram_wdata = bus.cpu_wdata;
    bus.hram_write = rst && bus.cpu_write && (region == HRAM);
  end

  always_comb begin
    src_d       = src_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    oam_write_d = in_xfer;
    oam_addr_d  = oam_addr_q;
    oam_wdata_d = oam_wdata_q;

    if ((state_q == START) && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end

    if (in_xfer) begin
      oam_addr_d  = idx_q;
      oam_wdata_d = bus.mem_rdata;
      idx_d       = (idx_q == LAST_IDX) ? 8'd0 : (idx_q + 8'd1);
    end

    if (reg_wr) begin
      src_d = bus.cpu_wdata;
      idx_d = 8'd0;
      cnt_d = DELAY_INIT;
    end

    // Stays high one clk past the last read so the trailing OAM write is covered.
    dma_active_d = (state_d != IDLE) || oam_write_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q        <= 8'hFF;
      idx_q        <= 8'd0;
      cnt_q        <= 8'd0;
      oam_addr_q   <= 8'd0;
      oam_wdata_q  <= 8'd0;
      oam_write_q  <= 1'b0;
      dma_active_q <= 1'b0;
    end else begin
      src_q        <= src_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      oam_addr_q   <= oam_addr_d;
      oam_wdata_q  <= oam_wdata_d;
      oam_write_q  <= oam_write_d;
      dma_active_q <= dma_active_d;
    end
  end

  assign bus.oam_addr   = oam_addr_q;
  assign bus.oam_wdata  = oam_wdata_q;
  assign bus.oam_write  = oam_write_q;
  assign bus.dma_active = dma_active_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: directed transfers with literal checks, then
// random core traffic, all checked every clk against a cycle-count model.
module tb_oam_dma_arbiter;

  localparam int OAM_N = 160;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  oam_dma_arbiter_if bus();

  oam_dma_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  function automatic logic [7:0] hram_fn(input logic [6:0] a);
    return {a, 1'b1} ^ 8'h5C;
  endfunction

  function automatic logic [7:0] page(input logic [7:0] s);
    int p;
    p = s;
    if (p >= 224) p = p - 32;
    return 8'(p);
  endfunction

  assign bus.mem_rdata  = mem_fn(bus.mem_addr);
  assign bus.hram_rdata = hram_fn(bus.hram_addr);

  int nvec = 0;
  int nmis = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_k counts clks since the last source write (1 = START,
  // 2..OAM_N+1 = source reads), m_p* is the OAM write due in this clk.
  int         m_k = 0;
  logic [7:0] m_src = 8'hFF;
  bit         m_pv = 1'b0;
  logic [7:0] m_pidx = 8'h00;
  logic [7:0] m_pdat = 8'h00;

  initial begin : compare
    logic [15:0] a;
    logic [15:0] e_maddr;
    logic [7:0]  e_rd;
    bit is_dma, is_hram, is_main, xfer;
    int idx;
    forever begin
      @(negedge clk);
      a       = bus.cpu_addr;
      is_dma  = (a == 16'hFF46);
      is_hram = !is_dma && (a >= 16'hFF80) && (a <= 16'hFFFE);
      is_main = !is_dma && !is_hram;
      xfer    = (m_k >= 2) && (m_k <= OAM_N + 1);
      idx     = m_k - 2;
      e_maddr = xfer ? {page(m_src), 8'(idx)} : a;
      if (is_dma)       e_rd = m_src;
      else if (is_hram) e_rd = hram_fn(a[6:0]);
      else if (xfer)    e_rd = 8'hFF;
      else              e_rd = mem_fn(a);

      if (armed) begin
        chk("mem_addr", bus.mem_addr, e_maddr);
        chk("mem_write", bus.mem_write, rst && !xfer && bus.cpu_write && is_main);
        if (!xfer) chk("mem_wdata", bus.mem_wdata, bus.cpu_wdata);
        chk("cpu_rdata", bus.cpu_rdata, e_rd);
        chk("hram_addr", bus.hram_addr, a[6:0]);
        chk("hram_wdata", bus.hram_wdata, bus.cpu_wdata);
        chk("hram_write", bus.hram_write, rst && bus.cpu_write && is_hram);
        chk("oam_write", bus.oam_write, m_pv);
        if (m_pv) begin
          chk("oam_addr", bus.oam_addr, m_pidx);
          chk("oam_wdata", bus.oam_wdata, m_pdat);
        end
        chk("dma_active", bus.dma_active, (m_k != 0) || m_pv);
      end

      if (!rst) begin
        m_src = 8'hFF;
        m_k   = 0;
        m_pv  = 1'b0;
      end else begin
        m_pv = xfer;
        if (xfer) begin
          m_pidx = 8'(idx);
          m_pdat = mem_fn(e_maddr);
        end
        if (bus.cpu_write && is_dma) begin
          m_src = bus.cpu_wdata;
          m_k   = 1;
        end else if (m_k == OAM_N + 1) begin
          m_k = 0;
        end else if (m_k != 0) begin
          m_k = m_k + 1;
        end
      end
    end
  end

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_write = w;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dma(input logic [7:0] s);
    drive(16'hFF46, s, 1'b1);
    cyc();
  endtask

  // Runs clks j0..jn after a source write with an idle core; checks mem_addr
  // at two chosen clks and counts dma_active clks and OAM writes from clk 2 on.
  task automatic watch(input int j0, input int jn,
                       input int ja, input logic [15:0] ea,
                       input int jb, input logic [15:0] eb,
                       output int act, output int nw);
    act = 0;
    nw  = 0;
    for (int j = j0; j <= jn; j++) begin
      drive(16'h0000, 8'h00, 1'b0);
      #2;
      if (bus.dma_active) act++;
      if (bus.oam_write && (j >= 2)) nw++;
      if (j == ja) chk("watch_addr_a", bus.mem_addr, ea);
      if (j == jb) chk("watch_addr_b", bus.mem_addr, eb);
      cyc();
    end
  endtask

  initial begin : stim
    int act, nw, act2, nw2;
    int r, sel;
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;

    drive(16'h0000, 8'h00, 1'b0);
    rst = 1'b0;
    repeat (2) cyc();
    armed = 1'b1;
    drive(16'h8000, 8'h33, 1'b1);
    #2;
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_oam_write", bus.oam_write, 1'b0);
    chk("rst_oam_addr", bus.oam_addr, 8'h00);
    chk("rst_oam_wdata", bus.oam_wdata, 8'h00);
    chk("rst_dma_active", bus.dma_active, 1'b0);
    cyc();
    drive(16'hFF90, 8'h33, 1'b1);
    #2;
    chk("rst_hram_write", bus.hram_write, 1'b0);
    cyc();
    drive(16'hFF46, 8'h00, 1'b0);
    #2;
    chk("rst_src", bus.cpu_rdata, 8'hFF);
    rst = 1'b1;
    cyc();

    drive(16'h8123, 8'h5A, 1'b1);
    #2;
    chk("pass_mem_write", bus.mem_write, 1'b1);
    chk("pass_mem_addr", bus.mem_addr, 16'h8123);
    chk("pass_mem_wdata", bus.mem_wdata, 8'h5A);
    cyc();

    start_dma(8'h12);
    drive(16'hFF46, 8'h00, 1'b0);
    #2;
    chk("src_readback", bus.cpu_rdata, 8'h12);
    cyc();
    watch(2, 163, 2, 16'h1200, 161, 16'h129F, act, nw);

    start_dma(8'hC1);
    act = 0;
    nw  = 0;
    for (int j = 1; j <= 163; j++) begin
      case (j)
        10:      drive(16'hC000, 8'h77, 1'b0);
        11:      drive(16'hC000, 8'h77, 1'b1);
        12:      drive(16'hFF90, 8'h00, 1'b0);
        default: drive(16'h4000, 8'h00, 1'b0);
      endcase
      #2;
      if (bus.dma_active) act++;
      if (bus.oam_write) nw++;
      if (j == 1)   chk("c1_start_core_bus", bus.mem_addr, 16'h4000);
      if (j == 2)   chk("c1_first_src", bus.mem_addr, 16'hC100);
      if (j == 161) chk("c1_last_src", bus.mem_addr, 16'hC19F);
      if (j == 3)   chk("c1_first_oam", {bus.oam_write, bus.oam_addr}, 9'h100);
      if (j == 162) chk("c1_last_oam", {bus.oam_write, bus.oam_addr}, 9'h19F);
      if (j == 10) begin
        chk("xfer_rd_main", bus.cpu_rdata, 8'hFF);
        chk("xfer_addr_not_core", bus.mem_addr != 16'hC000, 1'b1);
      end
      if (j == 11) chk("xfer_wr_drop", bus.mem_write, 1'b0);
      if (j == 12) chk("xfer_hram_rd", bus.cpu_rdata, hram_fn(7'h10));
      cyc();
    end
    chk("c1_active_len", act, 162);
    chk("c1_oam_count", nw, 160);

    start_dma(8'hF3);
    watch(1, 163, 2, 16'hD300, 161, 16'hD39F, act, nw);
    chk("f3_oam_count", nw, 160);
    start_dma(8'hE0);
    watch(1, 163, 2, 16'hC000, 161, 16'hC09F, act, nw);
    start_dma(8'hDF);
    watch(1, 163, 2, 16'hDF00, 161, 16'hDF9F, act, nw);

    start_dma(8'h55);
    watch(1, 41, 2, 16'h5500, 41, 16'h5527, act, nw);
    drive(16'hFF46, 8'h80, 1'b1);
    #2;
    chk("restart_idx40", bus.mem_addr, 16'h5528);
    if (bus.dma_active) act++;
    cyc();
    chk("restart_pre_active", act, 42);
    watch(1, 163, 2, 16'h8000, 161, 16'h809F, act2, nw2);
    chk("restart_active", act2, 162);
    chk("restart_oam_count", nw2, 160);

    start_dma(8'h42);
    watch(1, 76, 2, 16'h4200, 76, 16'h424A, act, nw);
    drive(16'h0000, 8'h00, 1'b0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    drive(16'hFF46, 8'h00, 1'b0);
    #2;
    chk("rstmid_oam_write", bus.oam_write, 1'b0);
    chk("rstmid_dma_active", bus.dma_active, 1'b0);
    chk("rstmid_src", bus.cpu_rdata, 8'hFF);
    cyc();
    watch(1, 170, 1, 16'h0000, 100, 16'h0000, act, nw);
    chk("rstmid_no_oam", nw, 0);
    chk("rstmid_no_active", act, 0);

    start_dma(8'hA0);
    watch(1, 160, 2, 16'hA000, 160, 16'hA09E, act, nw);
    drive(16'hFF46, 8'h30, 1'b1);
    #2;
    chk("simul_final_read", bus.mem_addr, 16'hA09F);
    cyc();
    drive(16'h0000, 8'h00, 1'b0);
    #2;
    chk("simul_final_oam", {bus.oam_write, bus.oam_addr}, 9'h19F);
    chk("simul_active", bus.dma_active, 1'b1);
    cyc();
    watch(2, 163, 2, 16'h3000, 161, 16'h309F, act, nw);
    chk("simul_oam_count", nw, 160);

    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 999);
      sel = $urandom_range(0, 9);
      w   = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      case (sel)
        0, 1, 2, 3: a = 16'($urandom);
        4, 5:       a = 16'hFF80 + 16'($urandom_range(0, 126));
        6: begin
          case ($urandom_range(0, 6))
            0:       a = 16'hFF7F;
            1:       a = 16'hFF80;
            2:       a = 16'hFFFE;
            3:       a = 16'hFFFF;
            4:       a = 16'hFF45;
            5:       a = 16'hFF47;
            default: a = 16'hFF46;
          endcase
        end
        default:    a = 16'($urandom_range(0, 16'h7FFF));
      endcase
      if (a == 16'hFF46) w = 1'b0;
      if (r < 4) begin
        a = 16'hFF46;
        w = 1'b1;
        case ($urandom_range(0, 4))
          0:       d = 8'hE0;
          1:       d = 8'hDF;
          2:       d = 8'hFF;
          default: d = 8'($urandom);
        endcase
      end
      rst = (r == 999) ? 1'b0 : 1'b1;
      drive(a, d, w);
      cyc();
    end

    rst = 1'b1;
    drive(16'h0000, 8'h00, 1'b0);
    repeat (170) cyc();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
# oam_dma_arbiter

Shares the single external memory bus between the sm83 core and an OAM DMA engine. It sits between the core's `addr`/`d_in`/`d_out`/`write` pins and the system memory map. It also owns the DMA source register at FF46 and a private HRAM port, so the core keeps running from HRAM while a DMA transfer holds the main bus. Each DMA transfer copies 160 bytes from `{src,8'h00}` to OAM at one byte per clk.

## Interface
- `OAM_BYTES`, default 160: bytes per transfer.
- `DMA_REG`, default 16'hFF46: address of the DMA source register.
- `START_DELAY`, default 1: idle clks between the FF46 write and the first source read.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset.
- `cpu_addr`  in  16  core address.
- `cpu_wdata`  in  8  core write data.
- `cpu_write`  in  1  core write strobe.
- `cpu_rdata`  out  8  read data returned to the core.
- `mem_addr`  out  16  main bus address.
- `mem_wdata`  out  8  main bus write data.
- `mem_write`  out  1  main bus write strobe.
- `mem_rdata`  in  8  main bus read data, combinational, valid in the same clk.
- `hram_addr`  out  7  HRAM offset, equal to `cpu_addr[6:0]`.
- `hram_wdata`  out  8  HRAM write data.
- `hram_write`  out  1  HRAM write strobe.
- `hram_rdata`  in  8  HRAM read data.
- `oam_addr`  out  8  OAM byte index, registered.
- `oam_wdata`  out  8  OAM write data, registered.
- `oam_write`  out  1  OAM write strobe, registered.
- `dma_active`  out  1  high from START through the last OAM write.

## Operation
- Address decode of `cpu_addr`:
  - HRAM: FF80–FFFE.
  - DMA register: `DMA_REG`.
  - Everything else is MAIN.
- HRAM is always served on the hram port, in every state. `hram_write` = `cpu_write` && HRAM.
- DMA register:
  - A write latches `src <= cpu_wdata` and is never forwarded to the main bus.
  - A read returns `src`, in every state.
- States are IDLE, START and XFER.
  - IDLE: the main bus is transparent. `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`, `mem_write`=`cpu_write`&&MAIN, `cpu_rdata`=`mem_rdata`.
  - Any state, on a DMA register write: go to START, load the delay counter with `START_DELAY`, clear `idx`, latch `src`.
  - START: the core keeps the main bus. Decrement the delay counter and go to XFER when it reaches 0.
  - XFER:
    - Bus outputs: `mem_addr`={`eff_src`, `idx`}, `mem_write`=0.
    - Register `mem_rdata` into `oam_wdata`, register `idx` into `oam_addr`, and assert `oam_write` in the next clk.
    - Increment `idx`. After `idx`=`OAM_BYTES`−1 is read, go to IDLE. The pipelined OAM write still completes in the following clk, with `dma_active` held high for it.
- `eff_src` = `src` ≥ 8'hE0 ? `src` − 8'h20 : `src`.
- Core accesses to MAIN during XFER:
  - Reads return 8'hFF.
  - Writes are dropped.
  - HRAM and DMA register accesses are unaffected.
- Restart: a DMA register write during START or XFER aborts the current transfer. The arbiter re-enters START with the new `src` and `idx`=0. `dma_active` stays high throughout. OAM bytes already written are not rolled back.
- `idx` is 8-bit and never exceeds `OAM_BYTES`−1. There is no wrap-around across the source page.

## Timing
- The FF46 write is sampled at posedge T.
  - START occupies T+1.
  - Source reads occur at T+2 … T+161.
  - OAM writes occur at T+3 … T+162.
  - `dma_active` is high from T+1 through T+162 inclusive.
- Core blocking covers exactly the XFER clks, T+2 … T+161.
- Latency from source read to OAM write is 1 clk.
- Decode and mux paths are combinational. The OAM outputs, `dma_active` and `src` are registered.
- Reset values while `rst`=0: state IDLE, `src`=8'hFF, `idx`=0, `oam_addr`=0, `oam_wdata`=0, `oam_write`=0, `dma_active`=0. `mem_write` and `hram_write` are forced to 0.
- Reset mid-transfer: the transfer is abandoned immediately and no further OAM writes occur.
- Simultaneous events: a DMA register write in the same clk as the final XFER read takes priority and restarts the transfer. The pipelined OAM write for that final byte still issues.

## Structure
- Shared package contents:
  - `dma_state_t` (IDLE, START, XFER).
  - `region_t` (MAIN, HRAM, DMAREG).
  - Constants `HRAM_LO`=16'hFF80, `HRAM_HI`=16'hFFFE, `DMA_REG_ADDR`, `OAM_BYTES`.
- One sub-module: `bus_decode_m`, combinational, taking `cpu_addr` and returning `region_t`.

## Test plan
- `src`=8'hC1 via an FF46 write at T: `mem_addr` runs C100…C19F over T+2…T+161. OAM writes run index 0…159 over T+3…T+162. `dma_active` is high for 162 clks.
- Core reads C000 during XFER: `cpu_rdata`=FF and `mem_addr` ≠ C000. A core write to C000 gives `mem_write`=0. A core read of FF90 returns `hram_rdata`.
- `src`=8'hF3: source addresses D300…D39F.
- Restart at XFER `idx`=40 with `src`=8'h80: the next START is followed by reads from 8000. `dma_active` never drops. 160 further OAM writes occur.
- `rst` low at `idx`=75: `oam_write`=0, `dma_active`=0 and `src`=FF on the next clk. No further OAM writes occur.
- IDLE passthrough: a core write of 8'h5A to 8123 drives `mem_write`=1, `mem_addr`=8123, `mem_wdata`=5A. A read of FF46 after writing 8'h12 returns 12.
